// File: rtl/text_sequencer.sv
// text_sequencer
// Queues glyph codes and feeds them one at a time to a font writer, keeping a
// text cursor (X, line-start X, Y, screen) that advances after each glyph and
// performs line feeds on code 63 or when the next glyph would not fit.
//
// Ports
//   Clock        single rising-edge clock
//   Reset        synchronous, active-low reset
//   PushValid    enqueue request for {PushColor, PushChar}
//   PushChar     6-bit glyph code (63 = newline control)
//   PushColor    glyph colour bit
//   PushReady    queue is not full
//   SetPos       cursor load strobe for PosX / PosY / PosScr
//   PosX, PosY   cursor position to load (PosX also becomes line-start X)
//   PosScr       screen select to load
//   ClearErr     clears the sticky Overflow / Timeout flags
//   FwBusy       font writer cannot accept a command yet
//   FwEnd        font writer finished the current glyph
//   SetInitPosX  one-cycle strobe, InitPosX holds the glyph's X position
//   Start        one-cycle strobe the cycle after SetInitPosX
//   InitPosX     X position of the glyph being drawn
//   InitPosY     current cursor Y
//   InitScr      current screen select
//   CharNumber   glyph code of the entry last taken from the queue
//   CharColor    colour of the entry last taken from the queue
//   Busy         sequencer active or cursor update pending
//   FifoCount    number of queued entries
//   Overflow     sticky: a push arrived while the queue was full
//   Timeout      sticky: font writer did not report FwEnd in time
module text_sequencer #(
  parameter int FIFO_DEPTH = 16,
  parameter int CHAR_PITCH = 7,
  parameter int LINE_PITCH = 9,
  parameter int X_LIMIT    = 320,
  parameter int TIMEOUT    = 1023
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       PushValid,
  input  logic [5:0] PushChar,
  input  logic       PushColor,
  output logic       PushReady,
  input  logic       SetPos,
  input  logic [8:0] PosX,
  input  logic [6:0] PosY,
  input  logic       PosScr,
  input  logic       ClearErr,
  input  logic       FwBusy,
  input  logic       FwEnd,
  output logic       Start,
  output logic       SetInitPosX,
  output logic [8:0] InitPosX,
  output logic [6:0] InitPosY,
  output logic       InitScr,
  output logic [5:0] CharNumber,
  output logic       CharColor,
  output logic       Busy,
  output logic [4:0] FifoCount,
  output logic       Overflow,
  output logic       Timeout
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [5:0] NEWLINE = 6'd63;

  typedef enum logic [2:0] {IDLE, POP, LOAD, START, WAIT, ADV} state_t;

  state_t        state;

  // Character queue
  logic [6:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count;
  logic [4:0]    count_next;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;
  logic [6:0]    head;

  // Cursor and pending cursor load
  logic [8:0]    cur_x;
  logic [8:0]    line_x;
  logic [6:0]    cur_y;
  logic          cur_scr;
  logic          pend;
  logic [8:0]    pend_x;
  logic [6:0]    pend_y;
  logic          pend_scr;

  logic [TW-1:0] wait_cnt;
  logic          timeout_hit;

  // Advance arithmetic, done wide so no intermediate sum can wrap.
  logic [9:0]    adv_x;
  logic          wrap_x;
  logic [7:0]    feed_y;
  logic          wrap_y;
  logic [6:0]    next_y;

  assign full    = (count == 5'(FIFO_DEPTH));
  assign empty   = (count == 5'd0);
  assign do_push = PushValid && !full;
  assign do_pop  = (state == POP);
  assign head    = mem[rd_ptr];

  // NOTE: every variable driven from always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 5'd1;
      2'b01:   count_next = count - 5'd1;
      default: count_next = count;
    endcase
  end

  always_comb begin
    adv_x       = {1'b0, cur_x} + 10'(CHAR_PITCH);
    wrap_x      = ({1'b0, adv_x} + 11'(CHAR_PITCH)) > 11'(X_LIMIT);
    feed_y      = {1'b0, cur_y} + 8'(LINE_PITCH);
    // Wrap to the top when the line after the new one would not fit.
    wrap_y      = ({1'b0, feed_y} + 9'(LINE_PITCH)) > 9'd127;
    next_y      = wrap_y ? 7'd0 : feed_y[6:0];
    timeout_hit = (state == WAIT) && !FwEnd && (wait_cnt == TW'(TIMEOUT - 1));
  end

  // NOTE: the storage array has no reset; only the pointers and count define
  // what is valid, so clearing the contents would add logic for nothing.
  always_ff @(posedge Clock) begin
    if (do_push) mem[wr_ptr] <= {PushColor, PushChar};
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      PushReady <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      count     <= count_next;
      PushReady <= (count_next != 5'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state       <= IDLE;
      cur_x       <= '0;
      line_x      <= '0;
      cur_y       <= '0;
      cur_scr     <= 1'b0;
      pend        <= 1'b0;
      pend_x      <= '0;
      pend_y      <= '0;
      pend_scr    <= 1'b0;
      wait_cnt    <= '0;
      Start       <= 1'b0;
      SetInitPosX <= 1'b0;
      InitPosX    <= '0;
      CharNumber  <= '0;
      CharColor   <= 1'b0;
      Overflow    <= 1'b0;
      Timeout     <= 1'b0;
    end else begin
      Start       <= 1'b0;
      SetInitPosX <= 1'b0;

      // Outside IDLE a cursor load is parked; the latest one wins.
      if (SetPos && state != IDLE) begin
        pend     <= 1'b1;
        pend_x   <= PosX;
        pend_y   <= PosY;
        pend_scr <= PosScr;
      end

      case (state)
        IDLE: begin
          if (SetPos) begin
            cur_x   <= PosX;
            line_x  <= PosX;
            cur_y   <= PosY;
            cur_scr <= PosScr;
            pend    <= 1'b0;
          end else if (pend) begin
            // A load parked across a timeout is applied here so Busy clears.
            cur_x   <= pend_x;
            line_x  <= pend_x;
            cur_y   <= pend_y;
            cur_scr <= pend_scr;
            pend    <= 1'b0;
          end
          if (!empty) state <= POP;
        end

        POP: begin
          CharNumber <= head[5:0];
          CharColor  <= head[6];
          state      <= (head[5:0] == NEWLINE) ? ADV : LOAD;
        end

        LOAD: begin
          if (!FwBusy) begin
            SetInitPosX <= 1'b1;
            InitPosX    <= cur_x;
            state       <= START;
          end
        end

        START: begin
          Start    <= 1'b1;
          wait_cnt <= '0;
          state    <= WAIT;
        end

        WAIT: begin
          if (FwEnd)            state <= ADV;
          else if (timeout_hit) state <= IDLE;
          else                  wait_cnt <= wait_cnt + TW'(1);
        end

        ADV: begin
          state <= IDLE;
          pend  <= 1'b0;
          if (SetPos) begin
            cur_x   <= PosX;
            line_x  <= PosX;
            cur_y   <= PosY;
            cur_scr <= PosScr;
          end else if (pend) begin
            cur_x   <= pend_x;
            line_x  <= pend_x;
            cur_y   <= pend_y;
            cur_scr <= pend_scr;
          end else if (CharNumber == NEWLINE || wrap_x) begin
            cur_x <= line_x;
            cur_y <= next_y;
          end else begin
            cur_x <= adv_x[8:0];
          end
        end

        default: state <= IDLE;
      endcase

      // Sticky errors; a clear beats a coincident set.
      if (ClearErr)               Overflow <= 1'b0;
      else if (PushValid && full) Overflow <= 1'b1;

      if (ClearErr)         Timeout <= 1'b0;
      else if (timeout_hit) Timeout <= 1'b1;
    end
  end

  assign InitPosY  = cur_y;
  assign InitScr   = cur_scr;
  assign Busy      = (state != IDLE) || pend;
  assign FifoCount = count;

endmodule

// File: tb/tb_text_sequencer.sv
// Directed testbench for text_sequencer: reset, basic draw, line and screen
// wrap, newline, timeout, queue overflow and drain order, cursor load during
// a draw, and reset in the middle of a draw.
module tb_text_sequencer;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       PushValid = 1'b0;
  logic [5:0] PushChar = '0;
  logic       PushColor = 1'b0;
  logic       PushReady;
  logic       SetPos = 1'b0;
  logic [8:0] PosX = '0;
  logic [6:0] PosY = '0;
  logic       PosScr = 1'b0;
  logic       ClearErr = 1'b0;
  logic       FwBusy = 1'b0;
  logic       FwEnd = 1'b0;
  logic       Start;
  logic       SetInitPosX;
  logic [8:0] InitPosX;
  logic [6:0] InitPosY;
  logic       InitScr;
  logic [5:0] CharNumber;
  logic       CharColor;
  logic       Busy;
  logic [4:0] FifoCount;
  logic       Overflow;
  logic       Timeout;

  int checks = 0;
  int errors = 0;

  text_sequencer dut (
    .Clock(Clock), .Reset(Reset),
    .PushValid(PushValid), .PushChar(PushChar), .PushColor(PushColor),
    .PushReady(PushReady),
    .SetPos(SetPos), .PosX(PosX), .PosY(PosY), .PosScr(PosScr),
    .ClearErr(ClearErr), .FwBusy(FwBusy), .FwEnd(FwEnd),
    .Start(Start), .SetInitPosX(SetInitPosX), .InitPosX(InitPosX),
    .InitPosY(InitPosY), .InitScr(InitScr),
    .CharNumber(CharNumber), .CharColor(CharColor),
    .Busy(Busy), .FifoCount(FifoCount), .Overflow(Overflow), .Timeout(Timeout)
  );

  always #5 Clock = ~Clock;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_pos(input logic [8:0] x, input logic [6:0] y, input logic s);
    SetPos = 1'b1; PosX = x; PosY = y; PosScr = s;
    step();
    SetPos = 1'b0;
  endtask

  // Push one glyph from IDLE and follow it to its Start pulse.
  task automatic issue(input logic [5:0] code, input logic [8:0] exp_x, input logic [6:0] exp_y);
    PushValid = 1'b1; PushChar = code; PushColor = code[0];
    step();
    PushValid = 1'b0;
    step();
    step();
    step();
    check("set_init_pulse", SetInitPosX, 1);
    check("init_pos_x", InitPosX, exp_x);
    check("start_early", Start, 0);
    step();
    check("start_pulse", Start, 1);
    check("set_init_single", SetInitPosX, 0);
    check("char_number", CharNumber, code);
    check("char_color", CharColor, code[0]);
    check("init_pos_y", InitPosY, exp_y);
  endtask

  // Return FwEnd `delay` cycles after Start and let the cursor advance.
  task automatic finish(input int delay);
    step();
    check("start_single", Start, 0);
    repeat (delay - 1) step();
    FwEnd = 1'b1;
    step();
    FwEnd = 1'b0;
    step();
  endtask

  initial begin
    logic [5:0] exp_code;

    // Reset state
    step();
    step();
    check("rst_push_ready", PushReady, 0);
    check("rst_busy", Busy, 0);
    check("rst_count", FifoCount, 0);
    check("rst_start", Start, 0);
    check("rst_init_y", InitPosY, 0);
    Reset = 1'b1;
    step();
    check("rel_push_ready", PushReady, 1);

    // Basic draw at (10,20), FwEnd 12 cycles after Start
    set_pos(9'd10, 7'd20, 1'b1);
    check("setpos_y", InitPosY, 20);
    check("setpos_scr", InitScr, 1);
    issue(6'd1, 9'd10, 7'd20);
    finish(12);
    check("basic_final_x", dut.cur_x, 17);
    check("basic_idle", Busy, 0);

    // Last column: drawn at 308, then back to line start with Y+9
    set_pos(9'd308, 7'd20, 1'b0);
    issue(6'd5, 9'd308, 7'd20);
    finish(2);
    check("edge_x_wrap", dut.cur_x, 308);
    check("edge_y_feed", InitPosY, 29);

    // Newline at Y=117 wraps to 0 with no font-writer command
    set_pos(9'd40, 7'd117, 1'b0);
    PushValid = 1'b1; PushChar = 6'd63;
    step();
    PushValid = 1'b0;
    step();
    step();
    check("nl_busy", Busy, 1);
    check("nl_no_set_init", SetInitPosX, 0);
    check("nl_no_start", Start, 0);
    check("nl_code", CharNumber, 63);
    step();
    check("nl_y_wrap", InitPosY, 0);
    check("nl_x_linestart", dut.cur_x, 40);
    check("nl_idle", Busy, 0);

    // Timeout after 1023 WAIT cycles, cursor unchanged, then cleared
    issue(6'd9, 9'd40, 7'd0);
    repeat (1022) step();
    check("to_not_yet", Timeout, 0);
    check("to_still_busy", Busy, 1);
    step();
    check("to_set", Timeout, 1);
    check("to_idle", Busy, 0);
    check("to_x_kept", dut.cur_x, 40);
    ClearErr = 1'b1;
    step();
    ClearErr = 1'b0;
    check("to_clear", Timeout, 0);

    // Overflow: one glyph stalled in LOAD, then 17 pushes
    FwBusy = 1'b1;
    PushValid = 1'b1; PushChar = 6'd10;
    step();
    PushValid = 1'b0;
    step();
    step();
    for (int i = 0; i < 16; i++) begin
      PushValid = 1'b1; PushChar = 6'(20 + i);
      step();
    end
    check("full_ready", PushReady, 0);
    check("full_count", FifoCount, 16);
    check("full_no_ovf", Overflow, 0);
    PushChar = 6'd36;
    step();
    check("ovf_set", Overflow, 1);
    check("ovf_count", FifoCount, 16);
    ClearErr = 1'b1;
    step();
    check("ovf_clear_priority", Overflow, 0);
    ClearErr = 1'b0;
    step();
    PushValid = 1'b0;
    check("ovf_reset", Overflow, 1);
    FwBusy = 1'b0;
    for (int n = 0; n < 17; n++) begin
      exp_code = (n == 0) ? 6'd10 : 6'(19 + n);
      for (int k = 0; k < 20 && Start !== 1'b1; k++) step();
      check("drain_start_seen", Start, 1);
      check("drain_order", CharNumber, exp_code);
      FwEnd = 1'b1;
      step();
      FwEnd = 1'b0;
    end
    step();
    check("drain_empty", FifoCount, 0);
    check("drain_idle", Busy, 0);
    check("drain_ovf_sticky", Overflow, 1);
    ClearErr = 1'b1;
    step();
    ClearErr = 1'b0;

    // Cursor load during WAIT takes effect after the current glyph
    set_pos(9'd100, 7'd10, 1'b1);
    issue(6'd7, 9'd100, 7'd10);
    step();
    set_pos(9'd50, 7'd30, 1'b0);
    check("pend_busy", Busy, 1);
    check("pend_y_held", InitPosY, 10);
    FwEnd = 1'b1;
    step();
    FwEnd = 1'b0;
    step();
    check("pend_x_applied", dut.cur_x, 50);
    check("pend_y_applied", InitPosY, 30);
    check("pend_scr_applied", InitScr, 0);
    check("pend_idle", Busy, 0);
    issue(6'd8, 9'd50, 7'd30);
    finish(3);
    check("pend_next_x", dut.cur_x, 57);

    // Reset during WAIT abandons the glyph and flushes the queue
    issue(6'd11, 9'd57, 7'd30);
    step();
    PushValid = 1'b1; PushChar = 6'd12;
    step();
    PushValid = 1'b0;
    check("mid_count", FifoCount, 1);
    Reset = 1'b0;
    step();
    check("mr_start", Start, 0);
    check("mr_set_init", SetInitPosX, 0);
    check("mr_init_x", InitPosX, 0);
    check("mr_init_y", InitPosY, 0);
    check("mr_char", CharNumber, 0);
    check("mr_busy", Busy, 0);
    check("mr_count", FifoCount, 0);
    check("mr_ready", PushReady, 0);
    Reset = 1'b1;
    FwEnd = 1'b1;
    step();
    FwEnd = 1'b0;
    check("mr_rel_ready", PushReady, 1);
    repeat (6) step();
    check("mr_no_start", Start, 0);
    check("mr_stays_idle", Busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_sequencer.md
TEXT_SEQUENCER -- requirements
Module: text_sequencer

Interface
REQ-001 Parameters SHALL be: FIFO_DEPTH, default 16, character queue entries; CHAR_PITCH, default 7, X advance per glyph; LINE_PITCH, default 9, Y advance per line; X_LIMIT, default 320, first X column that is not drawable; TIMEOUT, default 1023, maximum cycles spent waiting for FwEnd.
REQ-002 Clock  in  1  single clock; all logic rising-edge.
REQ-003 Reset  in  1  synchronous, active-low reset.
REQ-004 PushValid  in  1  enqueue request; PushChar  in  6  glyph code; PushColor  in  1  glyph colour.
REQ-005 PushReady  out  1  high when the queue is not full.
REQ-006 SetPos  in  1  cursor load strobe; PosX  in  9; PosY  in  7; PosScr  in  1  screen select.
REQ-007 ClearErr  in  1  clears sticky error flags.
REQ-008 FwBusy  in  1, FwEnd  in  1: status returned from the font writer.
REQ-009 Start  out  1, SetInitPosX  out  1, InitPosX  out  9, InitPosY  out  7, InitScr  out  1, CharNumber  out  6, CharColor  out  1: command outputs to the font writer.
REQ-010 Busy  out  1; FifoCount  out  5; Overflow  out  1; Timeout  out  1.

Function
REQ-011 The queue SHALL be a FIFO_DEPTH x 7-bit synchronous FIFO holding {PushColor, PushChar}; a push is accepted when PushValid is high and the FIFO is not full.
REQ-012 A push while the FIFO is full SHALL be dropped and SHALL set Overflow, even if a pop occurs in the same cycle.
REQ-013 A push and a pop in the same cycle on a non-full FIFO SHALL leave FifoCount unchanged.
REQ-014 The FSM states SHALL be IDLE, POP, LOAD, START, WAIT, ADV.
REQ-015 IDLE->POP when the FIFO is non-empty; POP reads the head entry into the CharNumber/CharColor registers in one cycle.
REQ-016 Code 63 SHALL be the newline control: POP->ADV with a line feed; no font-writer command is issued.
REQ-017 Any other code: POP->LOAD; LOAD waits for FwBusy=0, then pulses SetInitPosX for exactly 1 cycle with InitPosX=cursor X, and goes to START.
REQ-018 START pulses Start for exactly 1 cycle (the cycle after SetInitPosX) and goes to WAIT.
REQ-019 WAIT->ADV on FwEnd=1; WAIT->IDLE with Timeout set if TIMEOUT cycles elapse without FwEnd; a timeout does not advance the cursor.
REQ-020 ADV, glyph case: X+=CHAR_PITCH; if the new X+CHAR_PITCH > X_LIMIT, X=line-start X and Y+=LINE_PITCH.
REQ-021 ADV, newline case: X=line-start X and Y+=LINE_PITCH.
REQ-022 Y wrap: if Y+LINE_PITCH > 127, Y=0.
REQ-023 ADV->IDLE.
REQ-024 SetPos in IDLE loads X, line-start X, Y and Scr the next cycle.
REQ-025 SetPos in any other state is held pending (last write wins) and applied on ADV->IDLE, replacing the ADV result.
REQ-026 InitPosY/InitScr SHALL be driven continuously from the cursor registers.
REQ-027 Busy SHALL be high in every state except IDLE, or when a SetPos is pending.
REQ-028 Overflow and Timeout are sticky; ClearErr clears both next cycle.
REQ-029 ClearErr takes priority over a simultaneous set event.
REQ-030 Latency: push into an empty FIFO while IDLE and FwBusy=0 -> SetInitPosX at cycle +3, Start at cycle +4.

Reset
REQ-031 Reset=0 at a rising edge SHALL force: FSM=IDLE, FIFO empty, cursor X/Y/Scr=0, pending SetPos cleared, and all outputs 0 (PushReady=1 once reset is released).
REQ-032 Reset asserted mid-WAIT abandons the character with no further Start.

Verification
REQ-033 SetPos X=10,Y=20; push 'A'(1); FwEnd 12 cycles after Start -> one SetInitPosX pulse with InitPosX=10, then one Start pulse with CharNumber=1, InitPosY=20; final X=17.
REQ-034 Cursor X=308, push a glyph -> drawn at 308, then X=line-start, Y+=9; cursor Y=117 + newline -> Y=0, no Start issued.
REQ-035 Hold FwEnd=0 -> Timeout=1 after 1023 WAIT cycles, FSM returns to IDLE; ClearErr -> Timeout=0.
REQ-036 17 pushes with no pops -> PushReady=0 after 16, Overflow=1, FifoCount=16; all 16 queued glyphs drawn in order.
REQ-037 SetPos X=50 during WAIT -> current glyph completes; next glyph at InitPosX=50.
REQ-038 Reset=0 during WAIT -> all outputs 0 next cycle, FifoCount=0.
